// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: round-robin front end feeding one AES job at a time to a byte-serial core.
// Optional WAIT watchdog is compiled in only when AES_SCHED_TIMEOUT_EN is defined.
module aes_job_scheduler #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [127:0] key_a,
  input  logic [127:0] msg_a,
  input  logic [127:0] key_b,
  input  logic [127:0] msg_b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         core_load,
  output logic [7:0]   core_key,
  output logic [7:0]   core_msg,
  input  logic         core_done,
  input  logic [7:0]   core_ct,
  output logic [127:0] ct,
  output logic         ct_valid,
  output logic         ct_id,
  input  logic         ct_ready,
  output logic         err
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, COLLECT, OUT} state_t;

  state_t       state_reg;
  logic [3:0]   cnt_reg;
  logic         last_b_reg;
  logic [127:0] key_sh_reg, msg_sh_reg, ct_reg;
  logic         core_load_reg, ct_valid_reg, ct_id_reg, err_reg;
  logic [7:0]   core_key_reg, core_msg_reg;
  logic         pick_a, pick_b, timeout;
  logic [127:0] key_sel, msg_sel;

  // A tie goes to whoever was not granted last; a lone requester always wins.
  assign pick_a  = req_a && (!req_b || last_b_reg);
  assign pick_b  = req_b && !pick_a;
  assign key_sel = pick_a ? key_a : key_b;
  assign msg_sel = pick_a ? msg_a : msg_b;

  assign gnt_a     = rst_n && (state_reg == IDLE) && pick_a;
  assign gnt_b     = rst_n && (state_reg == IDLE) && pick_b;
  assign core_load = core_load_reg;
  assign core_key  = core_key_reg;
  assign core_msg  = core_msg_reg;
  assign ct        = ct_reg;
  assign ct_valid  = ct_valid_reg;
  assign ct_id     = ct_id_reg;
  assign err       = err_reg;

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_reg;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (!rst_n || state_reg != WAIT) to_cnt_reg <= '0;
    else                             to_cnt_reg <= to_cnt_reg + 1'b1;
  end
  assign timeout = (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      last_b_reg    <= 1'b1;
      key_sh_reg    <= '0;
      msg_sh_reg    <= '0;
      ct_reg        <= '0;
      core_load_reg <= 1'b0;
      core_key_reg  <= '0;
      core_msg_reg  <= '0;
      ct_valid_reg  <= 1'b0;
      ct_id_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: if (pick_a || pick_b) begin
          core_load_reg <= 1'b1;
          core_key_reg  <= key_sel[127:120];
          core_msg_reg  <= msg_sel[127:120];
          key_sh_reg    <= {key_sel[119:0], 8'h00};
          msg_sh_reg    <= {msg_sel[119:0], 8'h00};
          ct_id_reg     <= pick_b;
          last_b_reg    <= pick_b;
          cnt_reg       <= '0;
          state_reg     <= LOAD;
        end
        LOAD: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == 4'd15) begin
            core_load_reg <= 1'b0;
            core_key_reg  <= '0;
            core_msg_reg  <= '0;
            state_reg     <= WAIT;
          end else begin
            core_key_reg <= key_sh_reg[127:120];
            core_msg_reg <= msg_sh_reg[127:120];
            key_sh_reg   <= {key_sh_reg[119:0], 8'h00};
            msg_sh_reg   <= {msg_sh_reg[119:0], 8'h00};
          end
        end
        WAIT: if (core_done) begin
          ct_reg    <= {ct_reg[119:0], core_ct};
          cnt_reg   <= 4'd1;
          state_reg <= COLLECT;
        end else if (timeout) begin
          err_reg   <= 1'b1;
          state_reg <= IDLE;
        end
        COLLECT: begin
          ct_reg  <= {ct_reg[119:0], core_ct};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == 4'd15) begin
            ct_valid_reg <= 1'b1;
            state_reg    <= OUT;
          end
        end
        OUT: if (ct_ready) begin
          ct_valid_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_job_scheduler.md
AES_JOB_SCHEDULER -- requirements
Module: aes_job_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, meaning the maximum number of cycles spent in WAIT before abort (effective only with AES_SCHED_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports req_a / req_b  input  1  job request from requester A / B.
REQ-005 SHALL have ports key_a, msg_a, key_b, msg_b  input  128  cipher key and plaintext per requester.
REQ-006 SHALL have ports gnt_a / gnt_b  output  1  one-cycle pulse when that requester's operands are captured.
REQ-007 SHALL have port core_load  output  1  high while key/message bytes are driven to the core.
REQ-008 SHALL have ports core_key / core_msg  output  8  byte-serial key and plaintext to the core.
REQ-009 SHALL have port core_done  input  1  core pulse marking the first ciphertext byte.
REQ-010 SHALL have port core_ct  input  8  byte-serial ciphertext from the core.
REQ-011 SHALL have port ct  output  128  assembled ciphertext.
REQ-012 SHALL have ports ct_valid  output  1 and ct_id  output  1; ct_id is 0 for A and 1 for B.
REQ-013 SHALL have port ct_ready  input  1  downstream accept.
REQ-014 SHALL have port err  output  1  one-cycle timeout-abort pulse.

Function
REQ-015 SHALL implement states IDLE, LOAD, WAIT, COLLECT, OUT.
REQ-016 SHALL, in IDLE, grant only when a req is high.
- Grant = gnt pulse in that cycle; operands and ct_id captured on the same edge; next state LOAD.
REQ-017 SHALL arbitrate round-robin.
- If both requesters request, grant the one not granted last.
- Last-granted register resets to B, so A wins the first tie.
- A single requester is always granted.
REQ-018 SHALL assert core_load for exactly 16 cycles, starting the cycle after gnt.
- core_key and core_msg carry bytes [127:120] first, [7:0] last.
- Outputs are 0 whenever core_load is low.
- After the 16th byte, next state WAIT.
REQ-019 SHALL ignore core_done in every state except WAIT.
REQ-020 SHALL, in WAIT, on core_done capture core_ct that same cycle as byte [127:120] and enter COLLECT.
- COLLECT captures the remaining 15 bytes on the next 15 cycles, MSB-first.
REQ-021 SHALL enter OUT after the 16th byte.
- ct_valid is high in OUT; ct and ct_id are stable while ct_valid is high.
REQ-022 SHALL complete the handshake on a cycle with ct_valid and ct_ready both high, then return to IDLE.
- ct_ready already high on the first OUT cycle completes in one cycle.
- At least one IDLE cycle follows every job.
REQ-023 SHALL treat a req dropped before its gnt as withdrawn; no grant is issued for it.
REQ-024 SHALL use 4-bit byte counters that wrap 15 to 0 on the state exit.
REQ-025 SHALL give the scheduler a one-job limit: no new grant outside IDLE, and reqs are held off meanwhile.

Reset
REQ-026 SHALL, on rst_n low at a rising edge, regardless of state (mid-LOAD, WAIT, COLLECT or OUT):
- go to IDLE;
- drive gnt_a, gnt_b, core_load, core_key, core_msg, ct, ct_valid, ct_id, err to 0;
- clear counters; set last-granted to B.
REQ-027 SHALL discard any in-flight job on reset with no ct_valid or err.

Configuration
REQ-028 SHALL compile the timeout watchdog only when AES_SCHED_TIMEOUT_EN is defined.
- Defined: a counter runs in WAIT; on reaching TIMEOUT_CYCLES with no core_done, pulse err for one cycle and return to IDLE with no ct_valid.
- The counter clears on WAIT entry.
REQ-029 SHALL, with AES_SCHED_TIMEOUT_EN undefined, wait in WAIT indefinitely and tie err to 0.

Verification
REQ-030 SHALL cover FIPS-197 vector: req_a, key 000102..0f, msg 00112233..ff; model core returns 69c4e0d8..c55a.
- Required: gnt_a 1 cycle; 16 core_load cycles, first byte 00/00; ct=69c4e0d86a7b0430d8cdb78070b4c55a; ct_id=0.
REQ-031 SHALL cover simultaneous req_a and req_b from reset held continuously.
- Required: grants in order A, B, A; ct_id sequence 0, 1, 0.
REQ-032 SHALL cover ct_ready held low 5 cycles in OUT.
- Required: ct_valid high 6 cycles, ct constant; no gnt during that time; IDLE after.
REQ-033 SHALL cover rst_n low for 1 cycle at LOAD byte 7, then req_b.
- Required: all outputs 0; next grant is gnt_b with 16 fresh load bytes.
REQ-034 SHALL cover core_done pulsed during LOAD.
- Required: ignored; job completes on the later WAIT core_done.
REQ-035 SHALL cover, with AES_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=20, no core_done.
- Required: err pulses 20 cycles after WAIT entry; no ct_valid; next req granted.
